// File: rtl/cpu_nic.sv
// Single-packet NIC buffers between the processor port and one mesh router port.
// Reads return one cycle later; a full output buffer drops CPU writes and a full input buffer refuses and drops arrivals.
module cpu_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:ADDR_WIDTH-1] addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di
);

    localparam logic [0:ADDR_WIDTH-1] ADDR_OUT_BUF  = 2'b00;
    localparam logic [0:ADDR_WIDTH-1] ADDR_OUT_STAT = 2'b01;
    localparam logic [0:ADDR_WIDTH-1] ADDR_IN_BUF   = 2'b10;
    localparam logic [0:ADDR_WIDTH-1] ADDR_IN_STAT  = 2'b11;

    logic [0:DATA_WIDTH-1] out_buf;
    logic                  out_full;
    logic [0:DATA_WIDTH-1] in_buf;
    logic                  in_full;

    logic                  send;
    logic                  cpu_wr;
    logic                  cpu_rd;
    logic                  consume;
    logic                  recv;
    logic [0:DATA_WIDTH-1] rd_dat;

    // Bit 0 of the packet is its VC; it may only leave when it matches the router's current polarity.
    assign send    = out_full & net_ro & (out_buf[0] == net_polarity);
    assign cpu_wr  = nicEn & nicWrEn & (addr == ADDR_OUT_BUF) & ~out_full;
    assign cpu_rd  = nicEn & ~nicWrEn;
    assign consume = cpu_rd & (addr == ADDR_IN_BUF) & in_full;
    assign recv    = net_si & ~in_full;
    assign net_ri  = reset & ~in_full;

    always_comb begin
        rd_dat = '0;
        unique case (addr)
            ADDR_OUT_BUF:  rd_dat = '0;
            ADDR_OUT_STAT: rd_dat = {{(DATA_WIDTH-1){1'b0}}, out_full};
            ADDR_IN_BUF:   rd_dat = in_buf;
            ADDR_IN_STAT:  rd_dat = {{(DATA_WIDTH-1){1'b0}}, in_full};
            default:       rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_buf  <= '0;
            out_full <= 1'b0;
            in_buf   <= '0;
            in_full  <= 1'b0;
            d_out    <= '0;
            net_do   <= '0;
            net_so   <= 1'b0;
        end else begin
            net_so <= send;
            if (send) begin
                net_do <= out_buf;
            end

            // send needs out_full=1 and cpu_wr needs out_full=0, so they never coincide.
            if (send) begin
                out_full <= 1'b0;
            end else if (cpu_wr) begin
                out_buf  <= d_in;
                out_full <= 1'b1;
            end

            if (consume) begin
                in_full <= 1'b0;
            end else if (recv) begin
                in_buf  <= net_di;
                in_full <= 1'b1;
            end

            if (cpu_rd) begin
                d_out <= rd_dat;
            end
        end
    end

endmodule

// File: tb/tb_cpu_nic.sv
// Directed bench for cpu_nic: CPU register access, router send/receive handshakes and reset.
module tb_cpu_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:1]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;

    int tests = 0;
    int fails = 0;

    cpu_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
        step();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        step();
        nicEn = 1'b0;
    endtask

    int          so_count;
    logic        pol_at_edge;

    initial begin
        reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = '0;

        // Reset and release
        step(); step();
        check("rst_net_ri", {63'b0, net_ri}, 64'd0);
        check("rst_net_so", {63'b0, net_so}, 64'd0);
        check("rst_d_out", d_out, 64'd0);
        check("rst_net_do", net_do, 64'd0);
        reset = 1'b1;
        step();
        check("rel_net_ri", {63'b0, net_ri}, 64'd1);
        cpu_read(2'b01);
        check("rd_out_stat_reset", d_out, 64'd0);
        cpu_read(2'b11);
        check("rd_in_stat_reset", d_out, 64'd0);
        check("net_so_idle", {63'b0, net_so}, 64'd0);

        // Send with toggling polarity: VC bit is 1, so it leaves on a polarity=1 edge
        net_ro = 1'b1; net_polarity = 1'b0;
        cpu_write(2'b00, 64'h8000_0000_0000_00AA);
        so_count = 0;
        for (int i = 0; i < 5; i++) begin
            net_polarity = ~net_polarity;
            pol_at_edge  = net_polarity;
            step();
            if (net_so) begin
                so_count++;
                check("send_pol", {63'b0, pol_at_edge}, 64'd1);
                check("send_do", net_do, 64'h8000_0000_0000_00AA);
            end
        end
        check("send_once", 64'(so_count), 64'd1);
        cpu_read(2'b01);
        check("out_stat_after_send", d_out, 64'd0);
        cpu_read(2'b00);
        check("rd_out_buf_zero", d_out, 64'd0);

        // Backpressure: second write dropped while full
        net_ro = 1'b0; net_polarity = 1'b0;
        cpu_write(2'b00, 64'h1);
        cpu_write(2'b00, 64'h2);
        cpu_read(2'b01);
        check("out_stat_full", d_out, 64'd1);
        net_ro = 1'b1; net_polarity = 1'b0;
        step();
        check("bp_so", {63'b0, net_so}, 64'd1);
        check("bp_do", net_do, 64'h1);
        so_count = 0;
        for (int i = 0; i < 4; i++) begin
            net_polarity = ~net_polarity;
            step();
            if (net_so) so_count++;
        end
        check("dropped_not_sent", 64'(so_count), 64'd0);
        check("net_do_holds", net_do, 64'h1);

        // Simultaneous send and write: send wins, write dropped
        net_ro = 1'b0;
        cpu_write(2'b00, 64'h3);
        net_ro = 1'b1; net_polarity = 1'b0;
        cpu_write(2'b00, 64'h4);
        check("simul_so", {63'b0, net_so}, 64'd1);
        check("simul_do", net_do, 64'h3);
        net_ro = 1'b0;
        cpu_read(2'b01);
        check("simul_out_stat", d_out, 64'd0);

        // Receive path
        net_si = 1'b1; net_di = 64'hDEAD_BEEF;
        step();
        net_si = 1'b0;
        check("rx_net_ri", {63'b0, net_ri}, 64'd0);
        cpu_read(2'b11);
        check("rx_in_stat", d_out, 64'd1);
        net_si = 1'b1; net_di = 64'h5;
        step();
        net_si = 1'b0;
        cpu_read(2'b10);
        check("rx_first_kept", d_out, 64'hDEAD_BEEF);
        check("rx_ri_after_consume", {63'b0, net_ri}, 64'd1);
        cpu_read(2'b11);
        check("rx_in_stat_empty", d_out, 64'd0);
        cpu_read(2'b10);
        check("rx_stale_read", d_out, 64'hDEAD_BEEF);
        check("rx_stale_ri", {63'b0, net_ri}, 64'd1);

        // Consume and arrival on the same edge: arrival discarded
        net_si = 1'b1; net_di = 64'h7;
        step();
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b10; net_di = 64'h9;
        step();
        nicEn = 1'b0; net_si = 1'b0;
        check("race_rd", d_out, 64'h7);
        check("race_ri", {63'b0, net_ri}, 64'd1);
        cpu_read(2'b11);
        check("race_in_stat", d_out, 64'd0);

        // Reset with both buffers full
        net_ro = 1'b0;
        cpu_write(2'b00, 64'hF000_0000_0000_0001);
        net_si = 1'b1; net_di = 64'h11;
        step();
        net_si = 1'b0;
        check("full_ri", {63'b0, net_ri}, 64'd0);
        reset = 1'b0; net_ro = 1'b1; net_polarity = 1'b1;
        step();
        check("mid_rst_so", {63'b0, net_so}, 64'd0);
        check("mid_rst_ri", {63'b0, net_ri}, 64'd0);
        check("mid_rst_do", net_do, 64'd0);
        reset = 1'b1;
        step();
        check("post_rst_so", {63'b0, net_so}, 64'd0);
        check("post_rst_ri", {63'b0, net_ri}, 64'd1);
        net_ro = 1'b0;
        cpu_read(2'b01);
        check("post_rst_out_stat", d_out, 64'd0);
        cpu_read(2'b11);
        check("post_rst_in_stat", d_out, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
